// File: rtl/logic_gate_lab_pkg.sv
// Shared mode codes and helpers for the logic gate lab.
package logic_gate_lab_pkg;

    localparam int MODE_W = 3;

    typedef logic [MODE_W-1:0] mode_t;

    localparam mode_t MODE_AND   = 3'd0;
    localparam mode_t MODE_OR    = 3'd1;
    localparam mode_t MODE_NAND  = 3'd2;
    localparam mode_t MODE_NOR   = 3'd3;
    localparam mode_t MODE_XOR   = 3'd4;
    localparam mode_t MODE_XNOR  = 3'd5;
    localparam mode_t MODE_NOT_A = 3'd6;
    localparam mode_t MODE_BUF_A = 3'd7;

    localparam mode_t MODE_RESET = MODE_NAND;

    // Next mode code; 7 wraps naturally to 0 in the 3-bit field.
    function automatic mode_t mode_step(mode_t m);
        return m + mode_t'(1);
    endfunction

endpackage

// File: rtl/logic_gate_lab_if.sv
// Board-side switch/LED bundle; master is the board (drives switches), slave is the lab core.
interface logic_gate_lab_if
    import logic_gate_lab_pkg::*;
#(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0]  I_P_A;
    logic [WIDTH-1:0]  I_P_B;
    logic              I_P_BTN_MODE;
    logic [WIDTH-1:0]  O_P_LED_A;
    logic [WIDTH-1:0]  O_P_LED_B;
    logic [WIDTH-1:0]  O_P_LED_GATE;
    logic [MODE_W-1:0] O_P_LED_MODE;

    modport master (
        output I_P_A, I_P_B, I_P_BTN_MODE,
        input  O_P_LED_A, O_P_LED_B, O_P_LED_GATE, O_P_LED_MODE
    );

    modport slave (
        input  I_P_A, I_P_B, I_P_BTN_MODE,
        output O_P_LED_A, O_P_LED_B, O_P_LED_GATE, O_P_LED_MODE
    );
endinterface

// File: rtl/switch_debouncer.sv
// One-bit 2-FF synchroniser followed by a stable-interval debouncer.
module switch_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic db
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // Synchronise, then count consecutive cycles of disagreement; any agreement restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            db    <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == db) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                db  <= sync2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/logic_gate_lab.sv
// Top: debounced operands and mode button, mode stepper and registered bitwise function.
module logic_gate_lab
    import logic_gate_lab_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic           I_P_CLK,
    input  logic           I_P_RST_N,
    logic_gate_lab_if.slave io
);
    logic [WIDTH-1:0] a_db;
    logic [WIDTH-1:0] b_db;
    logic             btn_db;
    logic             btn_q;
    mode_t            mode;
    logic [WIDTH-1:0] gate;
    logic [WIDTH-1:0] gate_next;

    for (genvar i = 0; i < WIDTH; i++) begin : g_op
        switch_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_a (
            .clk   (I_P_CLK),
            .rst_n (I_P_RST_N),
            .raw   (io.I_P_A[i]),
            .db    (a_db[i])
        );
        switch_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_b (
            .clk   (I_P_CLK),
            .rst_n (I_P_RST_N),
            .raw   (io.I_P_B[i]),
            .db    (b_db[i])
        );
    end

    switch_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_btn (
        .clk   (I_P_CLK),
        .rst_n (I_P_RST_N),
        .raw   (io.I_P_BTN_MODE),
        .db    (btn_db)
    );

    // Mode FSM: one step per rising edge of the debounced button; release and hold do nothing.
    always_ff @(posedge I_P_CLK or negedge I_P_RST_N) begin
        if (!I_P_RST_N) begin
            btn_q <= 1'b0;
            mode  <= MODE_RESET;
        end else begin
            btn_q <= btn_db;
            if (btn_db && !btn_q) begin
                mode <= mode_step(mode);
            end
        end
    end

    // Function mux over the current mode and debounced operands.
    always_comb begin
        gate_next = '0;
        case (mode)
            MODE_AND:   gate_next = a_db & b_db;
            MODE_OR:    gate_next = a_db | b_db;
            MODE_NAND:  gate_next = ~(a_db & b_db);
            MODE_NOR:   gate_next = ~(a_db | b_db);
            MODE_XOR:   gate_next = a_db ^ b_db;
            MODE_XNOR:  gate_next = ~(a_db ^ b_db);
            MODE_NOT_A: gate_next = ~a_db;
            MODE_BUF_A: gate_next = a_db;
            default:    gate_next = '0;
        endcase
    end

    // Result register: mode and operands are sampled together, so no mixed intermediate appears.
    always_ff @(posedge I_P_CLK or negedge I_P_RST_N) begin
        if (!I_P_RST_N) begin
            gate <= '0;
        end else begin
            gate <= gate_next;
        end
    end

    assign io.O_P_LED_A    = a_db;
    assign io.O_P_LED_B    = b_db;
    assign io.O_P_LED_GATE = gate;
    assign io.O_P_LED_MODE = mode;
endmodule
